// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: the MEM stage has priority over the loader/debug port,
// and a saturating starvation counter forces the loader through after STARVE_LIMIT denials.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // MEM-stage requester
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  // Loader/debug requester
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  // Memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_p_rvalid_p1;
  logic              r_l_rvalid_p1;
  logic [DATA_W-1:0] r_p_rdata_p1;
  logic [DATA_W-1:0] r_l_rdata_p1;

  logic w_force_l;
  logic w_l_gnt;
  logic w_p_gnt;
  logic w_p_rd;
  logic w_l_rd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LIMIT) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: combinational grant and memory mux
  assign w_force_l = (r_starve_cnt == LIMIT);
  assign w_l_gnt   = ~rst & l_req & (~p_req | w_force_l);
  assign w_p_gnt   = ~rst & p_req & ~w_l_gnt;
  assign w_p_rd    = w_p_gnt & ~p_we;
  assign w_l_rd    = w_l_gnt & ~l_we;

  assign p_gnt   = w_p_gnt;
  assign l_gnt   = w_l_gnt;
  assign p_stall = ~rst & p_req & ~w_p_gnt;

  assign mem_addr  = w_l_gnt ? l_addr  : p_addr;
  assign mem_wdata = w_l_gnt ? l_wdata : p_wdata;
  assign mem_we    = (w_p_gnt & p_we) | (w_l_gnt & l_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_l_gnt | ~l_req) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= sat_inc(r_starve_cnt);
    end
  end

  // Stage p1: registered read return
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_rvalid_p1 <= 1'b0;
      r_l_rvalid_p1 <= 1'b0;
      r_p_rdata_p1  <= '0;
      r_l_rdata_p1  <= '0;
    end else begin
      r_p_rvalid_p1 <= w_p_rd;
      r_l_rvalid_p1 <= w_l_rd;
      if (w_p_rd) r_p_rdata_p1 <= mem_rdata;
      if (w_l_rd) r_l_rdata_p1 <= mem_rdata;
    end
  end

  // A response in flight is dropped as soon as reset is seen, not one edge later
  assign p_rvalid = r_p_rvalid_p1 & ~rst;
  assign l_rvalid = r_l_rvalid_p1 & ~rst;
  assign p_rdata  = rst ? '0 : r_p_rdata_p1;
  assign l_rdata  = rst ? '0 : r_l_rdata_p1;

endmodule
